// File: rtl/hack_spi_rom_reader.sv
`default_nettype none
// =============================================================================
// Module   : hack_spi_rom_reader
// Brief    : Hack instruction fetch over an SPI READ (0x03) from serial SRAM.
//            Define HACK_SPI_SEQ_READ_EN for sequential-read continuation.
// Revision : 1.0 - initial release
// =============================================================================
module hack_spi_rom_reader #(
    parameter int ADDR_WIDTH = 15,
    parameter int DIV        = 1
) (
    input  logic                  wb_clk_i,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  req_ready,
    output logic                  rsp_valid,
    output logic [15:0]           rsp_data,
    output logic                  busy,
    output logic                  spi_cs_n,
    output logic                  spi_sck,
    output logic                  spi_mosi,
    input  logic                  spi_miso
);

`ifdef HACK_SPI_SEQ_READ_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_CMD = 3'd1, S_ADDR = 3'd2, S_DATA = 3'd3, S_GAP = 3'd4, S_HOLD = 3'd5
    } state_t;
    localparam logic [5:0] c_first_data = 6'd32;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_CMD = 3'd1, S_ADDR = 3'd2, S_DATA = 3'd3, S_GAP = 3'd4
    } state_t;
`endif

    localparam logic [7:0] c_cmd_read  = 8'h03;
    localparam logic [7:0] c_div_last  = 8'(DIV - 1);
    localparam logic [5:0] c_last_cmd  = 6'd7;
    localparam logic [5:0] c_last_addr = 6'd31;
    localparam logic [5:0] c_last_data = 6'd47;

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_div;
    logic [5:0]  r_bit;
    logic        r_sck;
    logic        r_cs_n;
    logic [31:0] r_shift;
    logic [15:0] r_rx;
    logic        r_rsp_valid;
    logic [15:0] r_rsp_data;
    logic        w_tick;
    logic        w_fall;
    logic        w_active;
    logic        w_accept;
    logic [23:0] w_byte_addr;
`ifdef HACK_SPI_SEQ_READ_EN
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] w_addr_inc;
    logic                  r_pending;
    localparam logic [ADDR_WIDTH-1:0] c_addr_one = 1;
    assign w_addr_inc = r_addr + c_addr_one;
`endif

    assign w_byte_addr = 24'(req_addr) << 1;
    assign w_tick      = (r_div == c_div_last);
    assign w_fall      = w_tick & r_sck;
    assign w_active    = (r_state == S_CMD) || (r_state == S_ADDR) || (r_state == S_DATA);

    assign spi_cs_n  = r_cs_n;
    assign spi_sck   = r_sck;
    assign spi_mosi  = r_shift[31];
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign busy      = (r_state != S_IDLE);
`ifdef HACK_SPI_SEQ_READ_EN
    assign req_ready = (r_state == S_IDLE) || (r_state == S_HOLD);
`else
    assign req_ready = (r_state == S_IDLE);
`endif

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = S_CMD;
                end
            end
            S_CMD:  if (w_fall && r_bit == c_last_cmd)  w_state_next = S_ADDR;
            S_ADDR: if (w_fall && r_bit == c_last_addr) w_state_next = S_DATA;
            S_DATA: begin
                if (w_fall && r_bit == c_last_data) begin
`ifdef HACK_SPI_SEQ_READ_EN
                    // Top word has no successor, so never hold the burst open there.
                    w_state_next = (&r_addr) ? S_GAP : S_HOLD;
`else
                    w_state_next = S_GAP;
`endif
                end
            end
            S_GAP: begin
                if (w_tick && r_bit == 6'd1) begin
`ifdef HACK_SPI_SEQ_READ_EN
                    w_state_next = r_pending ? S_CMD : S_IDLE;
`else
                    w_state_next = S_IDLE;
`endif
                end
            end
`ifdef HACK_SPI_SEQ_READ_EN
            S_HOLD: begin
                if (req_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = (req_addr == w_addr_inc) ? S_DATA : S_GAP;
                end
            end
`endif
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_div       <= '0;
            r_bit       <= '0;
            r_sck       <= 1'b0;
            r_cs_n      <= 1'b1;
            r_shift     <= '0;
            r_rx        <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
`ifdef HACK_SPI_SEQ_READ_EN
            r_addr      <= '0;
            r_pending   <= 1'b0;
`endif
        end else begin
            r_rsp_valid <= 1'b0;
            r_cs_n      <= (w_state_next == S_IDLE) || (w_state_next == S_GAP);
            if (w_accept) begin
                r_shift <= {c_cmd_read, w_byte_addr};
                r_div   <= '0;
                r_sck   <= 1'b0;
                r_bit   <= '0;
`ifdef HACK_SPI_SEQ_READ_EN
                r_addr    <= req_addr;
                r_pending <= (w_state_next == S_GAP);
                if (w_state_next == S_DATA) begin
                    r_bit   <= c_first_data;
                    r_shift <= '0;
                end
`endif
            end else if (w_active || r_state == S_GAP) begin
                if (!w_tick) begin
                    r_div <= r_div + 8'd1;
                end else begin
                    r_div <= '0;
                    if (r_state == S_GAP) begin
                        // GAP reuses the bit counter as a two-half-period phase count.
                        r_bit <= (w_state_next == S_GAP) ? r_bit + 6'd1 : 6'd0;
`ifdef HACK_SPI_SEQ_READ_EN
                        if (w_state_next != S_GAP) r_pending <= 1'b0;
`endif
                    end else if (!r_sck) begin
                        r_sck <= 1'b1;
                        if (r_state == S_DATA) r_rx <= {r_rx[14:0], spi_miso};
                    end else begin
                        r_sck   <= 1'b0;
                        r_shift <= {r_shift[30:0], 1'b0};
                        if (r_bit == c_last_data) begin
                            r_bit       <= '0;
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= r_rx;
                        end else begin
                            r_bit <= r_bit + 6'd1;
                        end
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/hack_spi_rom_reader.md
# hack_spi_rom_reader

Fetch engine that turns Hack CPU instruction-fetch requests into SPI READ transactions on an external serial SRAM holding the Hack program. It takes a word address from the CPU side and shifts out a READ command (0x03) with a 24-bit byte address, then shifts in one 16-bit instruction. The result is returned with a one-cycle valid pulse. It sits directly downstream of the Hack core's ROM port inside `wrapped_hack_soc_dffram`, and its SPI pins are routed to `io_out`/`io_in`/`io_oeb`.

## Interface
Parameters:
- `ADDR_WIDTH`, default 15: width of the word address; the Hack ROM holds 32K words.
- `DIV`, default 1: SCK half-period in `wb_clk_i` cycles; legal range is 1..255.

Ports:
- `wb_clk_i`  in  1: the single clock for the block.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  1: fetch request.
- `req_addr`  in  ADDR_WIDTH: Hack word address (PC).
- `req_ready`  out  1: high when a request can be accepted.
- `rsp_valid`  out  1: one-cycle pulse when the instruction is available.
- `rsp_data`  out  16: fetched instruction; holds its value until the next `rsp_valid`.
- `busy`  out  1: high whenever a transaction is in progress (any state except IDLE).
- `spi_cs_n`  out  1: SRAM chip select.
- `spi_sck`  out  1: SPI clock, mode 0.
- `spi_mosi`  out  1: data to SRAM.
- `spi_miso`  in  1: data from SRAM.

## Operation
- Reset values: `spi_cs_n`=1, `spi_sck`=0, `spi_mosi`=0, `req_ready`=1, `rsp_valid`=0, `rsp_data`=0x0000, `busy`=0.
- Reset is asynchronous. Asserting it mid-transaction forces CS high and SCK low immediately and abandons the fetch with no `rsp_valid`.
- FSM states: IDLE, CMD, ADDR, DATA, GAP, plus HOLD when the sequential-read option is compiled in.
- IDLE: `req_ready`=1. On `req_valid && req_ready`, capture `req_addr` and go to CMD.
- CMD: shift out 0x03, MSB first (8 bits).
- ADDR: shift out the 24-bit byte address {zero-extend(req_addr), 1'b0}, MSB first (24 bits).
- DATA: shift in 16 bits, MSB first, into `rsp_data`. Byte at address 2n is the high byte.
- After the last DATA bit: pulse `rsp_valid`, raise `spi_cs_n` in the same cycle, and go to GAP.
- GAP: CS stays high for 2·DIV cycles with `req_ready`=0, then return to IDLE.
- A single bit/phase counter (0..47) and a half-period divider counter (0..DIV-1) drive the whole sequence. Bit index and state advance on SCK falling transitions.
- `req_ready` is 0 in every state other than IDLE and HOLD.

## Timing
- SPI mode 0 framing:
  - `spi_mosi` changes only while SCK is low.
  - `spi_miso` is registered on the clock edge where SCK goes 0→1.
  - Each bit occupies 2·DIV clocks: DIV clocks with SCK low, then DIV clocks with SCK high.
- Start of transaction: one cycle after the request handshake, `spi_cs_n`=0, SCK=0, and MOSI carries bit 7 of the command.
- Full-transaction latency, handshake edge to `rsp_valid`: 1 + 96·DIV cycles. For DIV=1 this is 97 cycles.
- Request-to-request throughput without the sequential option: 1 + 96·DIV + 2·DIV cycles.
- `rsp_valid` is never asserted in the same cycle as `req_ready`=1, except in HOLD under `HACK_SPI_SEQ_READ_EN`.

## Configuration
- `HACK_SPI_SEQ_READ_EN` defined:
  - After DATA, the FSM goes to HOLD instead of GAP and keeps `spi_cs_n`=0, SCK=0, `req_ready`=1.
  - A request with `req_addr == last_addr+1` is a sequential hit. It goes straight to DATA, and latency is 1 + 32·DIV cycles.
  - Any other request is a miss. The FSM closes CS for 2·DIV cycles (GAP), then runs a full transaction. Latency for a miss is 1 + 2·DIV + 96·DIV cycles.
  - If `last_addr` is all ones, the FSM takes GAP rather than HOLD; there is no wrap continuation.
- `HACK_SPI_SEQ_READ_EN` undefined: HOLD does not exist, and every fetch is a full transaction.

## Test plan
- Reset, then idle: all outputs hold their reset values; `req_ready`=1; SCK stays low for 100 cycles.
- DIV=1, fetch addr 0x0005 with the SRAM model returning 0xEC10:
  - MOSI bitstream is 0x03 then 0x00000A.
  - `rsp_valid` pulses exactly at cycle 97 with `rsp_data`=0xEC10.
  - CS_n returns high for 2 cycles before `req_ready`=1.
- DIV=3, fetch addr 0x7FFF (data 0x0007): `rsp_valid` at cycle 289; byte address sent is 0x00FFFE; SCK period is 6 clocks.
- Pull `rst_n` low at cycle 40 of a fetch: CS_n=1 and SCK=0 asynchronously, with no `rsp_valid`. A new fetch after release completes normally.
- With `HACK_SPI_SEQ_READ_EN`, DIV=1, fetch 0x0010, 0x0011, then 0x0020:
  - 0x0010 completes at 97 cycles, 0x0011 at 33 cycles with CS held low, and 0x0020 at 1+2+96 = 99 cycles.
  - All three return the model's data correctly.
- Back-to-back `req_valid` held high without the macro: exactly one response per accepted request, and `req_ready` is low throughout each transaction.
